// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one W-bit add/subtract datapath among NREQ requesters.
// Define ADDER_ARB_SAT_EN to saturate the result on signed overflow.
module adder_arbiter #(
   parameter int unsigned W    = 24,
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0]   req_sub,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_r,
   output logic              rsp_c,
   output logic              rsp_n,
   output logic              rsp_v,
   output logic              rsp_z
);

   typedef enum logic [0:0] {StIdle, StResp} state_e;

   state_e         r_state, w_state_next;
   logic [IDW-1:0] r_ptr, w_ptr_next, w_gnt_idx;
   logic [IDW-1:0] r_id;
   logic [W-1:0]   r_r;
   logic           r_c, r_n, r_v, r_z;

   logic           w_found, w_can_grant, w_accept;
   logic [W-1:0]   w_a, w_b, w_bx, w_r;
   logic [W:0]     w_sum;
   logic           w_sub, w_c, w_n, w_v, w_z_raw, w_z;

   // Priority search starts at the pointer and wraps from NREQ-1 to 0.
   always_comb begin
      int idx;
      idx       = 0;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = (int'(r_ptr) + k) % int'(NREQ);
         if (!w_found && req_valid[idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = IDW'(idx);
         end
      end
   end

   assign w_can_grant = !rst && ((r_state == StIdle) || rsp_ready);

   always_comb begin
      req_ready = '0;
      if (w_can_grant && w_found) begin
         req_ready[w_gnt_idx] = 1'b1;
      end
   end

   assign w_accept = |(req_valid & req_ready);

   assign w_a     = req_a[int'(w_gnt_idx)*W +: W];
   assign w_b     = req_b[int'(w_gnt_idx)*W +: W];
   assign w_sub   = req_sub[w_gnt_idx];
   assign w_bx    = w_sub ? ~w_b : w_b;
   assign w_sum   = {1'b0, w_a} + {1'b0, w_bx} + {{W{1'b0}}, w_sub};
   assign w_c     = w_sum[W];
   assign w_z_raw = ~|w_sum[W-1:0];
   assign w_v     = (!w_sub && (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1])) ||
                    ( w_sub && (w_a[W-1] != w_b[W-1]) && (w_sum[W-1] != w_a[W-1]));

`ifdef ADDER_ARB_SAT_EN
   // Clamp toward the sign of A, which is the direction the true result overflowed.
   assign w_r = !w_v     ? w_sum[W-1:0] :
                w_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   assign w_z = w_v ? 1'b0 : w_z_raw;
`else
   assign w_r = w_sum[W-1:0];
   assign w_z = w_z_raw;
`endif

   assign w_n = w_r[W-1];

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      if (w_accept) begin
         w_state_next = StResp;
         w_ptr_next   = IDW'((int'(w_gnt_idx) + 1) % int'(NREQ));
      end else if ((r_state == StResp) && rsp_ready) begin
         w_state_next = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_id    <= '0;
         r_r     <= '0;
         r_c     <= 1'b0;
         r_n     <= 1'b0;
         r_v     <= 1'b0;
         r_z     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
         if (w_accept) begin
            r_id <= w_gnt_idx;
            r_r  <= w_r;
            r_c  <= w_c;
            r_n  <= w_n;
            r_v  <= w_v;
            r_z  <= w_z;
         end
      end
   end

   assign rsp_valid = (r_state == StResp);
   assign rsp_id    = r_id;
   assign rsp_r     = r_r;
   assign rsp_c     = r_c;
   assign rsp_n     = r_n;
   assign rsp_v     = r_v;
   assign rsp_z     = r_z;

endmodule
